// File: rtl/mcpu.sv
// mcpu: two-state (fetch/execute) 8-bit CPU with unified 256x16 RAM and 4-entry register file.
// Optional MCPU_JUMP_EN enables OP_JMP; otherwise it decodes as NOP.
module mcpu_ram #(
   parameter int INSTR_SIZE = 16,
   parameter int MEM_WORDS  = 256,
   localparam int AW        = $clog2(MEM_WORDS)
) (
   input  logic                  clock,
   input  logic [AW-1:0]         raddr,
   output logic [INSTR_SIZE-1:0] rdata,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [INSTR_SIZE-1:0] wdata
);
   logic [INSTR_SIZE-1:0] mem [0:MEM_WORDS-1];
   assign rdata = mem[raddr];
   always_ff @(posedge clock)
      if (we) mem[waddr] <= wdata;
endmodule

module mcpu_regfile #(
   parameter int WORD_SIZE = 8
) (
   input  logic                 clock,
   input  logic [1:0]           ra,
   input  logic [1:0]           rb,
   input  logic [1:0]           rc,
   output logic [WORD_SIZE-1:0] da,
   output logic [WORD_SIZE-1:0] db,
   output logic [WORD_SIZE-1:0] dc,
   input  logic                 we,
   input  logic [WORD_SIZE-1:0] wd
);
   logic [WORD_SIZE-1:0] R [0:3];
   assign da = R[ra];
   assign db = R[rb];
   assign dc = R[rc];
   always_ff @(posedge clock)
      if (we) R[rc] <= wd;
endmodule

module mcpu #(
   parameter int OPERAND_SIZE = 4,
   parameter int WORD_SIZE    = 8,
   parameter int INSTR_SIZE   = 16,
   parameter int MEM_WORDS    = 256,
   parameter logic [OPERAND_SIZE-1:0] OP_NOP           = 0,
   parameter logic [OPERAND_SIZE-1:0] OP_AND           = 1,
   parameter logic [OPERAND_SIZE-1:0] OP_OR            = 2,
   parameter logic [OPERAND_SIZE-1:0] OP_XOR           = 3,
   parameter logic [OPERAND_SIZE-1:0] OP_ADD           = 4,
   parameter logic [OPERAND_SIZE-1:0] OP_SUB           = 5,
   parameter logic [OPERAND_SIZE-1:0] OP_SHORT_TO_REG  = 6,
   parameter logic [OPERAND_SIZE-1:0] OP_LOAD_FROM_MEM = 7,
   parameter logic [OPERAND_SIZE-1:0] OP_STORE_TO_MEM  = 8,
   parameter logic [OPERAND_SIZE-1:0] OP_JMP           = 9
) (
   input logic clock,
   input logic reset
);
   localparam int AW = $clog2(MEM_WORDS);
   typedef enum logic {FETCH, EXECUTE} state_t;
   state_t state, state_nx;
   logic [AW-1:0] pc, pc_nx, addr, raddr;
   logic [INSTR_SIZE-1:0] ir, ir_nx, rdata, mem_wd;
   logic [OPERAND_SIZE-1:0] opcode, op1, op2, op3;
   logic [WORD_SIZE-1:0] da, db, dc, alu, reg_wd;
   logic reg_we, mem_we, is_alu;
   logic unused;
   assign opcode = ir[4*OPERAND_SIZE-1 -: OPERAND_SIZE];
   assign op1    = ir[3*OPERAND_SIZE-1 -: OPERAND_SIZE];
   assign op2    = ir[2*OPERAND_SIZE-1 -: OPERAND_SIZE];
   assign op3    = ir[OPERAND_SIZE-1:0];
   assign addr   = ir[AW-1:0];
   // single RAM read port: instruction address while fetching, operand address while executing
   assign raddr  = state == FETCH ? pc : addr;
   assign unused = ^{op1[OPERAND_SIZE-1:2], op2[OPERAND_SIZE-1:2], op3[OPERAND_SIZE-1:2], OP_NOP, OP_JMP};
   mcpu_ram #(.INSTR_SIZE(INSTR_SIZE), .MEM_WORDS(MEM_WORDS)) raminst (
      .clock(clock), .raddr(raddr), .rdata(rdata),
      .we(mem_we), .waddr(addr), .wdata(mem_wd)
   );
   mcpu_regfile #(.WORD_SIZE(WORD_SIZE)) regfileinst (
      .clock(clock), .ra(op2[1:0]), .rb(op3[1:0]), .rc(op1[1:0]),
      .da(da), .db(db), .dc(dc), .we(reg_we), .wd(reg_wd)
   );
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state <= FETCH;
         pc    <= '0;
         ir    <= '0;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         ir    <= ir_nx;
      end
   always_comb begin
      state_nx = state == FETCH ? EXECUTE : FETCH;
      ir_nx    = state == FETCH ? rdata : ir;
      pc_nx    = state == FETCH ? pc + 1'b1 : pc;
`ifdef MCPU_JUMP_EN
      if (state == EXECUTE && opcode == OP_JMP) pc_nx = addr;
`endif
      alu    = opcode == OP_AND ? da & db :
               opcode == OP_OR  ? da | db :
               opcode == OP_XOR ? da ^ db :
               opcode == OP_ADD ? da + db : da - db;
      is_alu = opcode inside {OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB};
      reg_wd = is_alu ? alu :
               opcode == OP_SHORT_TO_REG ? ir[WORD_SIZE-1:0] : rdata[WORD_SIZE-1:0];
      reg_we = state == EXECUTE && (is_alu || opcode == OP_SHORT_TO_REG || opcode == OP_LOAD_FROM_MEM);
      mem_we = state == EXECUTE && opcode == OP_STORE_TO_MEM;
      mem_wd = {{(INSTR_SIZE-WORD_SIZE){1'b0}}, dc};
   end
endmodule

// File: tb/tb_mcpu.sv
// tb_mcpu: directed-program bench for mcpu; preloads RAM/registers hierarchically and checks state.
module tb_mcpu;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int errors = 0;

   mcpu dut (.clock(clock), .reset(reset));

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] i3(input logic [3:0] op, a, b, c);
      return {op, a, b, c};
   endfunction

   function automatic logic [15:0] i8(input logic [3:0] op, a, input logic [7:0] imm);
      return {op, a, imm};
   endfunction

   task automatic hold_and_clear();
      reset = 1'b0;
      @(negedge clock);
      for (int i = 0; i < 256; i++) dut.raminst.mem[i] <= 16'h0000;
      for (int i = 0; i < 4; i++) dut.regfileinst.R[i] <= 8'h00;
      @(negedge clock);
   endtask

   task automatic go(input int n);
      @(negedge clock);
      reset = 1'b1;
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      // load/store/ALU program
      hold_and_clear();
      dut.raminst.mem[0] <= i8(6, 0, 8'h2C);
      dut.raminst.mem[1] <= i8(6, 1, 8'h58);
      dut.raminst.mem[2] <= i8(8, 0, 8'h2C);
      dut.raminst.mem[3] <= i8(8, 1, 8'h58);
      dut.raminst.mem[4] <= i8(7, 2, 8'h2C);
      dut.raminst.mem[5] <= i8(7, 3, 8'h58);
      dut.raminst.mem[6] <= i3(4, 0, 2, 3);
      dut.raminst.mem[7] <= i3(3, 1, 2, 3);
      go(16);
      check("prog_r0", {8'h0, dut.regfileinst.R[0]}, 16'h0084);
      check("prog_r1", {8'h0, dut.regfileinst.R[1]}, 16'h0074);
      check("prog_r2", {8'h0, dut.regfileinst.R[2]}, 16'h002C);
      check("prog_r3", {8'h0, dut.regfileinst.R[3]}, 16'h0058);
      check("prog_m44", dut.raminst.mem[44], 16'h002C);
      check("prog_m88", dut.raminst.mem[88], 16'h0058);
      check("prog_pc", {8'h0, dut.pc}, 16'h0008);

      // reset hold keeps RAM/registers, PC/IR cleared
      hold_and_clear();
      dut.raminst.mem[0] <= i3(4, 0, 2, 3);
      dut.regfileinst.R[0] <= 8'h11;
      dut.regfileinst.R[2] <= 8'h01;
      dut.regfileinst.R[3] <= 8'h02;
      run(5);
      check("rst_pc", {8'h0, dut.pc}, 16'h0000);
      check("rst_ir", dut.ir, 16'h0000);
      check("rst_r0", {8'h0, dut.regfileinst.R[0]}, 16'h0011);
      check("rst_m0", dut.raminst.mem[0], 16'h4023);

      // reset pulse during EXECUTE of an ADD aborts its write
      go(1);
      check("mid_state", {15'h0, dut.state}, 16'h0001);
      #2 reset = 1'b0;
      #1;
      check("mid_pc", {8'h0, dut.pc}, 16'h0000);
      check("mid_state0", {15'h0, dut.state}, 16'h0000);
      @(posedge clock);
      #1;
      check("mid_r0_held", {8'h0, dut.regfileinst.R[0]}, 16'h0011);
      go(2);
      check("mid_restart_r0", {8'h0, dut.regfileinst.R[0]}, 16'h0003);
      check("mid_restart_pc", {8'h0, dut.pc}, 16'h0001);

      // modulo-256 arithmetic; op1 upper bits ignored (5 -> R1)
      hold_and_clear();
      dut.regfileinst.R[2] <= 8'hF0;
      dut.regfileinst.R[3] <= 8'h20;
      dut.raminst.mem[0] <= i3(4, 0, 2, 3);
      dut.raminst.mem[1] <= i3(5, 1, 3, 2);
      dut.raminst.mem[2] <= i8(6, 2, 8'h00);
      dut.raminst.mem[3] <= i8(6, 3, 8'h01);
      dut.raminst.mem[4] <= i3(5, 5, 2, 3);
      go(4);
      check("wrap_add", {8'h0, dut.regfileinst.R[0]}, 16'h0010);
      check("wrap_sub", {8'h0, dut.regfileinst.R[1]}, 16'h0030);
      run(6);
      check("wrap_r2", {8'h0, dut.regfileinst.R[2]}, 16'h0000);
      check("wrap_r3", {8'h0, dut.regfileinst.R[3]}, 16'h0001);
      check("wrap_borrow", {8'h0, dut.regfileinst.R[1]}, 16'h00FF);

      // PC wraps from 255 back to 0
      hold_and_clear();
      dut.raminst.mem[255] <= i8(6, 0, 8'h11);
      go(512);
      check("pcwrap_r0", {8'h0, dut.regfileinst.R[0]}, 16'h0011);
      check("pcwrap_pc", {8'h0, dut.pc}, 16'h0000);
      check("pcwrap_state", {15'h0, dut.state}, 16'h0000);

      // undefined opcode 0xF changes nothing but PC
      hold_and_clear();
      dut.raminst.mem[0] <= 16'hF123;
      dut.raminst.mem[1] <= 16'hF6A5;
      dut.regfileinst.R[0] <= 8'hA1;
      dut.regfileinst.R[1] <= 8'hB2;
      dut.regfileinst.R[2] <= 8'hC3;
      dut.regfileinst.R[3] <= 8'hD4;
      go(4);
      check("undef_r0", {8'h0, dut.regfileinst.R[0]}, 16'h00A1);
      check("undef_r1", {8'h0, dut.regfileinst.R[1]}, 16'h00B2);
      check("undef_r2", {8'h0, dut.regfileinst.R[2]}, 16'h00C3);
      check("undef_r3", {8'h0, dut.regfileinst.R[3]}, 16'h00D4);
      check("undef_m23", dut.raminst.mem[8'h23], 16'h0000);
      check("undef_mA5", dut.raminst.mem[8'hA5], 16'h0000);
      check("undef_pc", {8'h0, dut.pc}, 16'h0002);

      // jump
      hold_and_clear();
      dut.raminst.mem[0]  <= i8(9, 0, 8'h10);
      dut.raminst.mem[1]  <= i8(6, 2, 8'h77);
      dut.raminst.mem[16] <= i8(6, 1, 8'h5A);
      go(4);
`ifdef MCPU_JUMP_EN
      check("jmp_r1", {8'h0, dut.regfileinst.R[1]}, 16'h005A);
      check("jmp_r2", {8'h0, dut.regfileinst.R[2]}, 16'h0000);
      check("jmp_pc", {8'h0, dut.pc}, 16'h0011);
`else
      check("nojmp_r1", {8'h0, dut.regfileinst.R[1]}, 16'h0000);
      check("nojmp_r2", {8'h0, dut.regfileinst.R[2]}, 16'h0077);
      check("nojmp_pc", {8'h0, dut.pc}, 16'h0002);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mcpu.md
# mcpu

Minimal multi-cycle 8-bit accumulator-free CPU with a unified 256×16 instruction/data RAM and a four-entry register file. It fetches and executes 16-bit instructions from RAM starting at address 0 after reset, and has no external buses. The block is the top level of the processor exercise: benches preload program and data through hierarchical access to its RAM and register-file instances, then check the architectural state.

## Interface
- OPERAND_SIZE, 4: width of each operand field; also the opcode width.
- WORD_SIZE, 8: register and ALU data width.
- INSTR_SIZE, 16: instruction/RAM word width.
- MEM_WORDS, 256: RAM depth (8-bit address).
- Opcode parameters, each OPERAND_SIZE bits: OP_NOP=0, OP_AND=1, OP_OR=2, OP_XOR=3, OP_ADD=4, OP_SUB=5, OP_SHORT_TO_REG=6, OP_LOAD_FROM_MEM=7, OP_STORE_TO_MEM=8, OP_JMP=9.
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- Required hierarchy: RAM instance `raminst` with array `mem[0:MEM_WORDS-1]` of INSTR_SIZE bits; register-file instance `regfileinst` with array `R[0:3]` of WORD_SIZE bits. Benches write both directly.

## Operation
- Instruction word: [15:12] opcode, [11:8] op1 (destination/source register), [7:4] op2, [3:0] op3, [7:0] imm8/addr8.
- Register index: low 2 bits of the operand field; upper 2 bits ignored.
- Two-state FSM: FETCH and EXECUTE.
  - FETCH: IR <= mem[PC]; PC <= PC+1 (8-bit, wraps 255->0); go to EXECUTE.
  - EXECUTE: perform the operation; go to FETCH.
- ALU ops: R[op1] <= R[op2] op R[op3]. AND, OR, XOR bitwise. ADD/SUB are modulo 2^8; carry/borrow discarded; no flags.
- OP_SHORT_TO_REG: R[op1] <= imm8.
- OP_LOAD_FROM_MEM: R[op1] <= mem[addr8][7:0].
- OP_STORE_TO_MEM: mem[addr8] <= {8'h00, R[op1]}.
- OP_NOP and any undefined opcode: no state change except PC.
- All-zero RAM words decode as NOP, so an uninitialised region is harmless. Execution runs forever and wraps around RAM.
- The RAM has a combinational read and a synchronous write. The register file has combinational reads for two ports plus op1 and one synchronous write port.
- Self-modifying code is allowed. A store to the address of a later instruction takes effect before that instruction is fetched.

## Timing
- Reset asserted (low): PC=0, IR=0, state=FETCH, immediately.
- RAM and register-file contents are not affected by reset. This allows preloading while reset is held.
- Reset asserted mid-instruction aborts it. A write whose edge has not yet occurred is not performed.
- Each instruction takes exactly 2 cycles.
- Instruction k (from address k after reset release) is fetched at rising edge 2k+1 and its result is visible after edge 2k+2.
- A store's mem write and a load's register write both occur at the EXECUTE edge. A load sees the RAM contents present before that edge.

## Configuration
- MCPU_JUMP_EN defined: OP_JMP sets PC <= addr8 at the EXECUTE edge. The next FETCH uses the new PC and the jump takes 2 cycles.
- MCPU_JUMP_EN undefined: OP_JMP is treated as NOP.

## Test plan
- Load/store/ALU program. Preload: mem[0]={6,R0,0x2C}, mem[1]={6,R1,0x58}, mem[2]={8,R0,0x2C}, mem[3]={8,R1,0x58}, mem[4]={7,R2,0x2C}, mem[5]={7,R3,0x58}, mem[6]={4,R0,R2,R3}, mem[7]={3,R1,R2,R3}. After 16 cycles following reset release, require:
  - R0=0x84, R1=0x74, R2=0x2C, R3=0x58;
  - mem[44]=0x002C, mem[88]=0x0058.
- Reset behaviour: hold reset low with preloaded RAM and registers; require PC=0 and contents unchanged. Pulse reset low mid-EXECUTE of an ADD; require no register write and restart from address 0.
- Arithmetic wrap: R2=0xF0, R3=0x20. ADD gives 0x10; SUB R3-R2 (op2=R3, op3=R2) gives 0x30; SUB 0x00-0x01 gives 0xFF.
- PC wrap: all-zero RAM except mem[255]={6,R0,0x11}; after 512 cycles require R0=0x11 and PC back in 0..1 region. Undefined opcode 0xF leaves all registers and RAM unchanged.
- With MCPU_JUMP_EN: mem[0]={9,0,0x10}, mem[16]={6,R1,0x5A}; require R1=0x5A after 4 cycles and mem[1] never executed. Without the macro, require mem[1] to execute at cycle 4.
